tx_polyphase_interp: RTL and testbench
======================================

TX_POLYPHASE_INTERP -- requirements
Module: tx_polyphase_interp

Interface
REQ-001 Parameter NTAPS, default 6: taps per polyphase branch.
REQ-002 Parameter COEF_W, default 8: signed coefficient width.
REQ-003 Parameter OUT_W, default COEF_W+3: signed output width; SHALL satisfy 2^(OUT_W-1) > NTAPS*2^(COEF_W-1).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 i_enable  input  1  advance one output phase this cycle.
REQ-008 i_symbol  input  1  BPSK symbol: 0 -> +1, 1 -> -1; sampled only when o_symbol_req and i_enable are both high.
REQ-009 i_coef_we  input  1  coefficient write strobe.
REQ-010 i_coef_addr  input  5  coefficient index = phase*NTAPS + tap.
REQ-011 i_coef_data  input  COEF_W  signed coefficient value.
REQ-012 o_sample  output  OUT_W  signed interpolated sample.
REQ-013 o_valid  output  1  o_sample/o_phase are new this cycle.
REQ-014 o_phase  output  2  polyphase branch that produced o_sample.
REQ-015 o_symbol_req  output  1  high while the internal phase is 3; the next symbol is consumed on this edge if enabled.

Function
REQ-016 The block SHALL be a 4x interpolating transmit pulse shaper: four output samples per input symbol, one per enabled cycle.
REQ-017 The internal 2-bit phase counter SHALL step 0,1,2,3,0,... on each enabled cycle and hold when i_enable=0.
REQ-018 The symbol delay line SHALL hold NTAPS symbols, sym[0] newest.
REQ-019 On an enabled edge with phase==3, the delay line SHALL shift in i_symbol at sym[0] and the phase SHALL wrap to 0; at no other time does the delay line change.
REQ-020 o_symbol_req SHALL be decoded from the registered phase (no combinational path from any input).
REQ-021 On each enabled edge, o_sample SHALL be loaded with SUM over k=0..NTAPS-1 of (sym[k] ? -c[p][k] : +c[p][k]), where p is the pre-edge phase, sym is the pre-edge delay line, and c is the pre-edge coefficient bank: 1-cycle latency.
REQ-022 On that same edge, o_phase SHALL be loaded with p and o_valid SHALL be loaded with 1.
REQ-023 On a non-enabled edge, o_valid SHALL be 0 and o_sample/o_phase SHALL hold.
REQ-024 The sum SHALL be full precision with sign extension to OUT_W; negation of -2^(COEF_W-1) SHALL be exact with no wrap and no saturation.
REQ-025 The coefficient bank SHALL be 4*NTAPS registers (24 by default); an i_coef_we edge with addr < 4*NTAPS SHALL write the register, independent of i_enable.
REQ-026 Writes with addr >= 4*NTAPS SHALL be ignored.
REQ-027 A write and a computation on the same edge: the computation SHALL use the old value, and the new value SHALL be used from the next enabled edge.

Reset
REQ-028 While i_reset_n=0, and immediately on its assertion without a clock edge, the block SHALL clear phase=0, all sym=0, all coefficients=0, o_sample=0, o_phase=0, o_valid=0, o_symbol_req=0.
REQ-029 Reset assertion mid-operation SHALL discard partial symbol progress.
REQ-030 After deassertion, the first enabled edge SHALL produce phase 0.
REQ-031 The block SHALL consume its first symbol at the fourth enabled edge after reset.

Verification
REQ-032 Reset: hold i_reset_n low, toggle all inputs -> all outputs 0, and a read-back of the coefficient bank via output sums is 0.
REQ-033 Impulse: write c[p][0]=16*(p+1) and all other coefficients 0, enable continuously, and present i_symbol=1 at the first o_symbol_req -> o_sample sequence 16,32,48,64,-16,-32,-48,-64 with o_phase 0,1,2,3,0,1,2,3 and o_valid high.
REQ-034 Extremes: all 24 coefficients = -128 and the stream is all ones -> o_sample=+768 in steady state; all coefficients = 127 and the stream is all zeros -> +762; no overflow.
REQ-035 Stall: deassert i_enable for 3 cycles while the internal phase is 2 -> o_valid low for 3 cycles, o_sample held, the output resumes with o_phase 2, and no symbol is consumed.
REQ-036 Coefficient port: writes to addr 24..31 leave the outputs unchanged; a write to c[1][0] on the edge that computes phase 1 -> the old value is used, and the new value is used from the next phase-1 sample.
REQ-037 Asynchronous reset: assert i_reset_n low between clock edges while the internal phase is 2 -> outputs clear before the next edge, and after release the sequence restarts at o_phase 0.

Source files
------------

// File: rtl/tx_polyphase_interp.sv
// 4x interpolating BPSK transmit pulse shaper: a polyphase FIR with one branch
// per output phase, an NTAPS-deep symbol delay line and a writable coefficient bank.
module tx_polyphase_interp #(
  parameter int NTAPS  = 6,
  parameter int COEF_W = 8,
  parameter int OUT_W  = COEF_W + 3
) (
  input  logic                     clk,
  input  logic                     i_reset_n,
  input  logic                     i_enable,
  input  logic                     i_symbol,
  input  logic                     i_coef_we,
  input  logic [4:0]               i_coef_addr,
  input  logic signed [COEF_W-1:0] i_coef_data,
  output logic signed [OUT_W-1:0]  o_sample,
  output logic                     o_valid,
  output logic [1:0]               o_phase,
  output logic                     o_symbol_req
);

  logic [1:0]               phase_q, phase_d;
  logic [NTAPS-1:0]         sym_q, sym_d;
  logic signed [COEF_W-1:0] coef_q [4][NTAPS];
  logic signed [COEF_W-1:0] coef_d [4][NTAPS];
  logic signed [OUT_W-1:0]  sample_q, sample_d;
  logic [1:0]               out_phase_q, out_phase_d;
  logic                     valid_q, valid_d;

  logic signed [OUT_W-1:0]  acc;
  logic signed [OUT_W-1:0]  term;
  logic signed [COEF_W-1:0] coef_sel;

  // Branch sum for the current phase; a '1' symbol maps to -1 and negates its tap.
  always_comb begin
    acc      = '0;
    term     = '0;
    coef_sel = '0;
    for (int k = 0; k < NTAPS; k++) begin
      coef_sel = coef_q[phase_q][k];
      term     = {{(OUT_W-COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
      // NOTE: blocking assignments here chain the accumulation within one
      // evaluation; in clocked blocks only non-blocking assignments are used.
      acc      = sym_q[k] ? (acc - term) : (acc + term);
    end
  end

  always_comb begin
    phase_d     = phase_q;
    sym_d       = sym_q;
    sample_d    = sample_q;
    out_phase_d = out_phase_q;
    valid_d     = 1'b0;
    if (i_enable) begin
      phase_d     = phase_q + 2'd1;
      sample_d    = acc;
      out_phase_d = phase_q;
      valid_d     = 1'b1;
      if (phase_q == 2'd3) begin
        sym_d = {sym_q[NTAPS-2:0], i_symbol};
      end
    end
  end

  // Out-of-range addresses never match an entry, so those writes fall away.
  always_comb begin
    coef_d = coef_q;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (i_coef_we && (i_coef_addr == 5'(p*NTAPS + k))) begin
          coef_d[p][k] = i_coef_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase_q     <= '0;
      sym_q       <= '0;
      sample_q    <= '0;
      out_phase_q <= '0;
      valid_q     <= 1'b0;
      // NOTE: the coefficient bank is a flop array, not a RAM, so it must be
      // cleared by reset like any other state.
      for (int p = 0; p < 4; p++) begin
        for (int k = 0; k < NTAPS; k++) begin
          coef_q[p][k] <= '0;
        end
      end
    end else begin
      phase_q     <= phase_d;
      sym_q       <= sym_d;
      sample_q    <= sample_d;
      out_phase_q <= out_phase_d;
      valid_q     <= valid_d;
      coef_q      <= coef_d;
    end
  end

  assign o_sample     = sample_q;
  assign o_phase      = out_phase_q;
  assign o_valid      = valid_q;
  assign o_symbol_req = (phase_q == 2'd3);

endmodule

// File: tb/tb_tx_polyphase_interp.sv
// Directed bench for tx_polyphase_interp: table-driven impulse/stall vectors plus
// hand-written sequences for reset, extremes, coefficient port and async reset.
module tb_tx_polyphase_interp;

  localparam int NTAPS  = 6;
  localparam int COEF_W = 8;
  localparam int OUT_W  = COEF_W + 3;

  logic                     clk;
  logic                     i_reset_n;
  logic                     i_enable;
  logic                     i_symbol;
  logic                     i_coef_we;
  logic [4:0]               i_coef_addr;
  logic signed [COEF_W-1:0] i_coef_data;
  logic signed [OUT_W-1:0]  o_sample;
  logic                     o_valid;
  logic [1:0]               o_phase;
  logic                     o_symbol_req;

  int checks   = 0;
  int failures = 0;

  tx_polyphase_interp #(.NTAPS(NTAPS), .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .i_enable     (i_enable),
    .i_symbol     (i_symbol),
    .i_coef_we    (i_coef_we),
    .i_coef_addr  (i_coef_addr),
    .i_coef_data  (i_coef_data),
    .o_sample     (o_sample),
    .o_valid      (o_valid),
    .o_phase      (o_phase),
    .o_symbol_req (o_symbol_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic en;
    logic sym;
    int   exp_sample;
    int   exp_phase;
    logic exp_valid;
    logic exp_req;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int s, input int ph, input logic v, input logic rq);
    check({tag, " sample"}, int'(o_sample), s);
    check({tag, " phase"},  int'(o_phase), ph);
    check({tag, " valid"},  int'(o_valid), int'(v));
    check({tag, " req"},    int'(o_symbol_req), int'(rq));
  endtask

  // All drives happen 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_enable  = 1'b0;
    i_symbol  = 1'b0;
    i_coef_we = 1'b0;
    i_reset_n = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  task automatic wr(input int addr, input int data);
    i_enable    = 1'b0;
    i_coef_we   = 1'b1;
    i_coef_addr = 5'(addr);
    i_coef_data = COEF_W'(data);
    tick();
    i_coef_we   = 1'b0;
  endtask

  task automatic run(input logic sym);
    i_enable = 1'b1;
    i_symbol = sym;
    tick();
  endtask

  task automatic set_vec(input int i, input logic en, input logic sym, input int s,
                         input int ph, input logic v, input logic rq);
    vecs[i].en         = en;
    vecs[i].sym        = sym;
    vecs[i].exp_sample = s;
    vecs[i].exp_phase  = ph;
    vecs[i].exp_valid  = v;
    vecs[i].exp_req    = rq;
  endtask

  initial begin
    // Impulse response, then a 3-cycle stall while the internal phase is 2.
    set_vec(0,  1, 0,  16, 0, 1, 0);
    set_vec(1,  1, 0,  32, 1, 1, 0);
    set_vec(2,  1, 0,  48, 2, 1, 1);
    set_vec(3,  1, 1,  64, 3, 1, 0);
    set_vec(4,  1, 0, -16, 0, 1, 0);
    set_vec(5,  1, 0, -32, 1, 1, 0);
    set_vec(6,  1, 0, -48, 2, 1, 1);
    set_vec(7,  1, 0, -64, 3, 1, 0);
    set_vec(8,  1, 0,  16, 0, 1, 0);
    set_vec(9,  1, 0,  32, 1, 1, 0);
    set_vec(10, 0, 1,  32, 1, 0, 0);
    set_vec(11, 0, 1,  32, 1, 0, 0);
    set_vec(12, 0, 1,  32, 1, 0, 0);
    set_vec(13, 1, 0,  48, 2, 1, 1);
    set_vec(14, 1, 0,  64, 3, 1, 0);
    set_vec(15, 1, 0,  16, 0, 1, 0);

    i_reset_n   = 1'b0;
    i_enable    = 1'b0;
    i_symbol    = 1'b0;
    i_coef_we   = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    #2;
    check_out("reset0", 0, 0, 0, 0);

    // Reset held with inputs toggling: nothing may leak into state.
    for (int c = 0; c < 4; c++) begin
      i_enable    = 1'b1;
      i_symbol    = 1'($urandom_range(0, 1));
      i_coef_we   = 1'b1;
      i_coef_addr = 5'($urandom_range(0, 23));
      i_coef_data = COEF_W'($urandom_range(1, 127));
      tick();
      check_out("reset_hold", 0, 0, 0, 0);
    end
    i_coef_we = 1'b0;
    i_enable  = 1'b0;
    i_reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      run(1'b0);
      check("reset_readback sample", int'(o_sample), 0);
      check("reset_readback phase", int'(o_phase), c % 4);
    end

    // Impulse and stall table.
    do_reset();
    for (int p = 0; p < 4; p++) wr(p*NTAPS, 16*(p+1));
    for (int i = 0; i < 16; i++) begin
      i_enable = vecs[i].en;
      i_symbol = vecs[i].sym;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].exp_sample, vecs[i].exp_phase,
                vecs[i].exp_valid, vecs[i].exp_req);
    end

    // Extremes: -128 everywhere with all-ones stream, then 127 with all-zeros.
    do_reset();
    for (int a = 0; a < 4*NTAPS; a++) wr(a, -128);
    for (int c = 0; c < 4*NTAPS; c++) run(1'b1);
    for (int c = 0; c < 4; c++) begin
      run(1'b1);
      check("ext_neg sample", int'(o_sample), 768);
      check("ext_neg phase", int'(o_phase), c);
    end
    for (int a = 0; a < 4*NTAPS; a++) wr(a, 127);
    for (int c = 0; c < 4*NTAPS; c++) run(1'b0);
    for (int c = 0; c < 4; c++) begin
      run(1'b0);
      check("ext_pos sample", int'(o_sample), 762);
    end

    // Coefficient port: out-of-range writes ignored, write/compute collision.
    do_reset();
    wr(6, 10);
    for (int a = 24; a < 32; a++) begin
      wr(a, 127);
      check("oor_hold valid", int'(o_valid), 0);
      check("oor_hold sample", int'(o_sample), 0);
    end
    for (int c = 0; c < 4; c++) begin
      run(1'b0);
      check("oor_sum", int'(o_sample), (c == 1) ? 10 : 0);
    end
    run(1'b0);
    check("collide p0", int'(o_sample), 0);
    i_coef_we   = 1'b1;
    i_coef_addr = 5'd6;
    i_coef_data = 8'sd20;
    run(1'b0);
    i_coef_we   = 1'b0;
    check("collide old", int'(o_sample), 10);
    check("collide phase", int'(o_phase), 1);
    run(1'b0);
    run(1'b0);
    run(1'b0);
    check("collide p0b", int'(o_sample), 0);
    run(1'b0);
    check("collide new", int'(o_sample), 20);

    // Asynchronous reset between edges with the internal phase at 2.
    do_reset();
    wr(0, 50);
    wr(6, 60);
    run(1'b0);
    run(1'b0);
    check("async pre sample", int'(o_sample), 60);
    i_enable = 1'b0;
    #3;
    i_reset_n = 1'b0;
    #1;
    check_out("async clear", 0, 0, 0, 0);
    tick();
    i_reset_n = 1'b1;
    wr(0, 50);
    run(1'b0);
    check_out("async restart", 50, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
